if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RV32I pipeline, directly upstream of the IF/ID register feeding the decoder.
- Owns the architectural PC and issues one-outstanding fetches to instruction memory over a req/gnt/rvalid handshake.
- Presents `instr_o`/`pc_o`/`valid_o` to IF/ID, honours `stall_i` from cpu_ctrl, and redirects on taken jumps/branches resolved in EX.

---
 rtl/if_stage_if.sv | 26 ++
 rtl/if_stage.sv | 133 +++++++++++++
 tb/tb_if_stage.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_stage_if.sv
// ============================================================================
//  Module   : if_stage_if
//  Purpose  : Instruction-memory fetch bus between the IF stage and imem.
//             One request outstanding at a time: req/addr are held until
//             gnt, and the response comes later as rvalid/rdata.
//  Signals  : req    - fetch request          (fetch side -> memory)
//             addr   - word-aligned address   (fetch side -> memory)
//             gnt    - request accepted       (memory -> fetch side)
//             rvalid - read data valid        (memory -> fetch side)
//             rdata  - read data              (memory -> fetch side)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface if_stage_if;
  logic        req;
  logic [31:0] addr;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, output addr, input gnt, input rvalid, input rdata);
  modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

`default_nettype wire

// File: rtl/if_stage.sv
// ============================================================================
//  Module   : if_stage
//  Purpose  : RV32I instruction-fetch stage. Owns the architectural PC,
//             issues one-outstanding fetches on the imem bus, and presents
//             fetched instructions to the IF/ID register. It honours the
//             downstream stall and redirects on taken jumps/branches from EX.
//  Ports    : clk, rst     - clock, synchronous active-high reset
//             stall_i      - downstream cannot accept; freeze outputs
//             jump_i       - taken jump/branch this cycle
//             jump_addr_i  - redirect target
//             imem         - fetch bus (master side)
//             instr_o      - fetched instruction (NOP_INSTR when bubble)
//             pc_o         - PC of instr_o
//             valid_o      - instr_o is a real instruction
//             error_o      - sticky misaligned-redirect error
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        stall_i,
  input  wire logic        jump_i,
  input  wire logic [31:0] jump_addr_i,
  if_stage_if.master       imem,
  output logic      [31:0] instr_o,
  output logic      [31:0] pc_o,
  output logic             valid_o,
  output logic             error_o
);

  // IDLE: requesting; WAIT: granted, awaiting data;
  // HOLD: data buffered while stalled; KILL: drop one stale response.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2,
    KILL = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] pc_r;
  logic [31:0] buf_data;
  logic [31:0] pc_plus4;

  // Modulo-2^32 increment: 0xFFFF_FFFC wraps to 0 without any error.
  assign pc_plus4  = pc_r + 32'd4;

  // Once a misaligned redirect has been seen, fetching stops until reset.
  assign imem.req  = (state == IDLE) && !error_o;
  assign imem.addr = pc_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      pc_r     <= RESET_PC;
      buf_data <= 32'd0;
      instr_o  <= NOP_INSTR;
      pc_o     <= RESET_PC;
      valid_o  <= 1'b0;
      error_o  <= 1'b0;
    end else if (jump_i) begin
      // Redirect overrides stall: the instruction path is flushed at once.
      pc_r    <= {jump_addr_i[31:2], 2'b00};
      instr_o <= NOP_INSTR;
      valid_o <= 1'b0;
      if (jump_addr_i[1:0] != 2'b00) begin
        error_o <= 1'b1;
      end
      case (state)
        // A grant this cycle means a response for the old PC is on its way.
        IDLE:    state <= (imem.req && imem.gnt) ? KILL : IDLE;
        WAIT:    state <= imem.rvalid ? IDLE : KILL;
        HOLD:    state <= IDLE;
        // If the stale response lands in the same cycle as a second redirect
        // it is already drained, so waiting on in KILL would never end.
        KILL:    state <= imem.rvalid ? IDLE : KILL;
        default: state <= IDLE;
      endcase
    end else begin
      // Default for an unstalled cycle is a bubble; presenting an
      // instruction below overrides it. A stalled cycle leaves outputs alone.
      if (!stall_i) begin
        instr_o <= NOP_INSTR;
        valid_o <= 1'b0;
      end
      case (state)
        IDLE: begin
          // Prefetch continues even while stalled; HOLD absorbs the result.
          if (imem.req && imem.gnt) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem.rvalid) begin
            if (stall_i) begin
              buf_data <= imem.rdata;
              state    <= HOLD;
            end else begin
              instr_o <= imem.rdata;
              pc_o    <= pc_r;
              valid_o <= 1'b1;
              pc_r    <= pc_plus4;
              state   <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            instr_o <= buf_data;
            pc_o    <= pc_r;
            valid_o <= 1'b1;
            pc_r    <= pc_plus4;
            state   <= IDLE;
          end
        end
        KILL: begin
          if (imem.rvalid) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_if_stage.sv
// ============================================================================
//  Module   : tb_if_stage
//  Purpose  : Self-checking bench for if_stage. Directed scenarios followed
//             by randomized traffic, all compared against a transaction-level
//             reference model (pending fetch / discard / buffered flags).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        error;

  if_stage_if imem ();

  if_stage #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall_i     (stall),
    .jump_i      (jump),
    .jump_addr_i (jump_addr),
    .imem        (imem),
    .instr_o     (instr),
    .pc_o        (pc),
    .valid_o     (valid),
    .error_o     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: what the fetch unit should be doing, in transaction terms.
  logic [31:0] m_pc;      // next address to fetch
  logic        m_pend;    // a granted request awaits its response
  logic        m_disc;    // that response must be thrown away
  logic        m_bufd;    // a response is parked while stalled
  logic [31:0] m_buf;
  logic        m_err;
  logic [31:0] m_instr;
  logic [31:0] m_pco;
  logic        m_valid;
  logic [31:0] gaddr;     // address of the most recently granted fetch

  function automatic logic m_req();
    return !m_pend && !m_bufd && !m_err;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h0050_0093;
      32'h0000_0004: return 32'h00A0_0113;
      32'h0000_0008: return 32'h1234_5678;
      32'h0000_0010: return 32'hDEAD_BEEF;
      default:       return {a[15:0], ~a[31:16]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic m_reset();
    m_pc = RESET_PC; m_pend = 0; m_disc = 0; m_bufd = 0; m_buf = 0;
    m_err = 0; m_instr = NOP_INSTR; m_pco = RESET_PC; m_valid = 0;
    gaddr = RESET_PC;
  endtask

  task automatic m_present(input logic [31:0] d);
    m_instr = d; m_pco = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
  endtask

  task automatic m_bubble(input logic s);
    if (!s) begin
      m_instr = NOP_INSTR; m_valid = 0;
    end
  endtask

  // One clock: drive inputs, check bus request, clock, check registered outputs.
  task automatic step(input logic r, input logic s, input logic j,
                      input logic [31:0] ja, input logic g, input logic rv);
    logic        req_now;
    logic [31:0] rd;
    rd        = mem_word(gaddr);
    rst       = r;
    stall     = s;
    jump      = j;
    jump_addr = ja;
    imem.gnt    = g;
    imem.rvalid = rv;
    imem.rdata  = rd;
    #1;
    req_now = m_req();
    chk("req", {31'd0, imem.req}, {31'd0, req_now});
    if (req_now) chk("addr", imem.addr, m_pc);
    @(posedge clk);
    if (r) begin
      m_reset();
    end else if (j) begin
      if (ja[1:0] != 2'b00) m_err = 1;
      if (g && req_now) gaddr = m_pc;
      m_pc = ja & ~32'd3;
      m_instr = NOP_INSTR; m_valid = 0; m_bufd = 0;
      if (m_pend) begin
        if (rv) begin m_pend = 0; m_disc = 0; end
        else m_disc = 1;
      end else if (g && req_now) begin
        m_pend = 1; m_disc = 1;
      end
    end else if (m_pend && rv) begin
      m_pend = 0;
      if (m_disc) begin
        m_disc = 0; m_bubble(s);
      end else if (s) begin
        m_bufd = 1; m_buf = rd;
      end else begin
        m_present(rd);
      end
    end else if (m_bufd && !s) begin
      m_bufd = 0; m_present(m_buf);
    end else begin
      if (g && req_now) begin m_pend = 1; gaddr = m_pc; end
      m_bubble(s);
    end
    #1;
    chk("instr", instr, m_instr);
    chk("pc",    pc,    m_pco);
    chk("valid", {31'd0, valid}, {31'd0, m_valid});
    chk("error", {31'd0, error}, {31'd0, m_err});
  endtask

  initial begin
    rst = 1; stall = 0; jump = 0; jump_addr = 0;
    imem.gnt = 0; imem.rvalid = 0; imem.rdata = 0;
    repeat (2) @(posedge clk);
    #1;
    m_reset();

    // Reset state, with a stray response during reset ignored.
    step(1, 0, 0, 0, 1, 1);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_instr", instr, NOP_INSTR);
    chk("rst_pc", pc, RESET_PC);

    // Back-to-back 1-cycle memory, no stall.
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("t1_instr0", instr, 32'h0050_0093);
    chk("t1_pc0", pc, 32'h0);
    chk("t1_valid0", {31'd0, valid}, 32'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("t1_bubble", {31'd0, valid}, 32'd0);
    step(0, 0, 0, 0, 0, 1);
    chk("t1_instr1", instr, 32'h00A0_0113);
    chk("t1_pc1", pc, 32'h4);

    // Response arrives while stalled: buffered, presented when stall drops.
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("t2_noreq", {31'd0, imem.req}, 32'd0);
    step(0, 0, 0, 0, 0, 0);
    chk("t2_instr", instr, 32'h1234_5678);
    chk("t2_pc", pc, 32'h8);
    chk("t2_next", imem.addr, 32'hC);

    // Redirect while waiting: the old response must vanish.
    step(0, 0, 1, 32'h10, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 1, 32'h40, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("t3_dropped", {31'd0, valid}, 32'd0);
    chk("t3_addr", imem.addr, 32'h40);

    // Jump coincident with rvalid under stall.
    step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 32'h80, 0, 1);
    chk("t4_valid", {31'd0, valid}, 32'd0);
    chk("t4_addr", imem.addr, 32'h80);
    chk("t4_req", {31'd0, imem.req}, 32'd1);

    // Misaligned redirect: sticky error, fetch halts until reset.
    step(0, 0, 1, 32'h42, 0, 0);
    chk("t5_err", {31'd0, error}, 32'd1);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("t5_halt", {31'd0, imem.req}, 32'd0);
    step(1, 0, 0, 0, 0, 0);
    chk("t5_clr", {31'd0, error}, 32'd0);
    chk("t5_restart", imem.addr, RESET_PC);

    // PC wraps from the top of the address space.
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("t6_pc", pc, 32'hFFFF_FFFC);
    chk("t6_wrap", imem.addr, 32'h0);
    chk("t6_err", {31'd0, error}, 32'd0);

    // Randomized traffic with variable memory latency and occasional
    // protocol-violating responses, which the design must ignore.
    for (int n = 0; n < 4000; n++) begin
      logic        r, s, j, g, rv;
      logic [31:0] ja;
      r  = (m_err && ($urandom_range(0, 7) == 0)) || ($urandom_range(0, 299) == 0);
      s  = ($urandom_range(0, 3) == 0);
      j  = ($urandom_range(0, 14) == 0);
      case ($urandom_range(0, 9))
        0:       ja = 32'hFFFF_FFFC;
        1:       ja = ($urandom & 32'h0000_03FF) | 32'h1;
        default: ja = $urandom & 32'h0000_03FC;
      endcase
      g  = m_req() && ($urandom_range(0, 1) == 1);
      rv = m_pend ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
      step(r, s, j, ja, g, rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
